// File: rtl/burst_memory_slave.sv
// Burst-capable 512x32 memory slave on a multiplexed address/data bus.
// Define BURST_MEMORY_SLAVE_BUSY_EN to throttle writes to one beat every two cycles via busy_out.
module burst_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h40000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic [31:0] address_data_in,
    input  logic        read_n_write_in,
    input  logic [3:0]  byte_enables_in,
    input  logic [7:0]  burst_size_in,
    input  logic        data_valid_in,
    input  logic        end_transaction_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, ERROR} state_t;

    state_t      state;
    state_t      stateNext;

    logic [31:0] mem [512];
    logic [8:0]  wordAddr;
    logic [8:0]  beatCnt;
    logic [7:0]  burstSize;
    logic [3:0]  byteEnables;

    logic        selected;
    logic        beginBad;
    logic [9:0]  lastWord;
    logic        readIssue;
    logic        writeBeat;
    logic        writeAccept;
    logic        writeOverrun;

    logic [31:0] rdData_p1;
    logic        vld_p1;
    logic        last_p1;

    assign selected     = begin_transaction_in && (address_data_in[31:11] == BASE_ADDRESS[31:11]);
    assign lastWord     = {1'b0, address_data_in[10:2]} + {2'b00, burst_size_in};
    assign beginBad     = (address_data_in[1:0] != 2'b00) || (lastWord > 10'd511);

    // An abort in the same cycle suppresses the read so no beat escapes afterwards.
    assign readIssue    = (state == READ) && (beatCnt <= {1'b0, burstSize}) && !end_transaction_in;
    assign writeBeat    = (state == WRITE) && data_valid_in && !busy_out;
    assign writeAccept  = writeBeat && (beatCnt <= {1'b0, burstSize});
    assign writeOverrun = writeBeat && !(beatCnt <= {1'b0, burstSize});

`ifdef BURST_MEMORY_SLAVE_BUSY_EN
    logic busyReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busyReg <= 1'b0;
        end else begin
            busyReg <= writeAccept;
        end
    end

    assign busy_out = busyReg;
`else
    assign busy_out = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (selected) begin
                    if (beginBad) begin
                        stateNext = ERROR;
                    end else if (read_n_write_in) begin
                        stateNext = READ;
                    end else begin
                        stateNext = WRITE;
                    end
                end
            end
            READ: begin
                if (end_transaction_in) begin
                    stateNext = IDLE;
                end else if (vld_p1 && last_p1) begin
                    stateNext = READ_END;
                end
            end
            READ_END: stateNext = IDLE;
            WRITE: begin
                if (writeOverrun) begin
                    stateNext = ERROR;
                end else if (end_transaction_in) begin
                    stateNext = IDLE;
                end
            end
            ERROR:    stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            wordAddr    <= '0;
            beatCnt     <= '0;
            burstSize   <= '0;
            byteEnables <= '0;
        end else begin
            state   <= stateNext;
            vld_p1  <= readIssue;
            last_p1 <= readIssue && (beatCnt == {1'b0, burstSize});
            if ((state == IDLE) && selected) begin
                wordAddr    <= address_data_in[10:2];
                beatCnt     <= '0;
                burstSize   <= burst_size_in;
                byteEnables <= byte_enables_in;
            end else if (readIssue || writeAccept) begin
                wordAddr <= wordAddr + 9'd1;
                beatCnt  <= beatCnt + 9'd1;
            end
        end
    end

    // p0 -> p1: synchronous RAM access, contents survive reset
    always_ff @(posedge clock) begin
        if (writeAccept) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEnables[b]) begin
                    mem[wordAddr][8*b +: 8] <= address_data_in[8*b +: 8];
                end
            end
        end
        rdData_p1 <= mem[wordAddr];
    end

    assign address_data_out    = vld_p1 ? rdData_p1 : 32'h0;
    assign data_valid_out      = vld_p1;
    assign end_transaction_out = (state == READ_END);
    assign error_out           = (state == ERROR);

endmodule

// File: doc/burst_memory_slave.md
BURST_MEMORY_SLAVE -- requirements
Module: burst_memory_slave

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h40000000, byte address of word 0; bits [10:0] SHALL be zero.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port begin_transaction_in  input  1  start of bus transaction; address, burst size, direction and byte enables are valid this cycle.
REQ-005 SHALL have port address_data_in  input  32  address in the begin cycle, write data otherwise.
REQ-006 SHALL have ports read_n_write_in (1), byte_enables_in (4), burst_size_in (8) as inputs; burst length = burst_size_in+1 words.
REQ-007 SHALL have ports data_valid_in and end_transaction_in as 1-bit inputs from the initiator.
REQ-008 SHALL have port address_data_out  output  32  read data, zero when not driving a beat.
REQ-009 SHALL have ports data_valid_out, end_transaction_out, busy_out, error_out as 1-bit outputs, zero whenever not asserted (wired-OR bus).

Function
REQ-010 SHALL contain a 512x32 synchronous RAM, word index = address[10:2].
REQ-011 SHALL use states IDLE, READ, READ_END, WRITE, ERROR.
REQ-012 IDLE: SHALL capture address, burst count, direction, byte enables when begin_transaction_in=1 and address[31:11]==BASE_ADDRESS[31:11]; otherwise SHALL stay IDLE and drive nothing.
REQ-013 SHALL go to ERROR when a selected begin has address[1:0]!=0 or word index + burst_size_in > 511.
REQ-014 ERROR: SHALL assert error_out for exactly one cycle, then return to IDLE; RAM unchanged.
REQ-015 READ: begin in cycle N SHALL yield first data_valid_out in cycle N+2, then one beat per cycle, burst_size_in+1 beats total, no gaps.
REQ-016 Read data SHALL be returned exactly as stored, no byte swapping.
REQ-017 READ_END: SHALL assert end_transaction_out for one cycle immediately after the last read beat, then IDLE.
REQ-018 end_transaction_in=1 during READ SHALL abort: no further beats, no end_transaction_out, IDLE next cycle.
REQ-019 WRITE: each cycle with data_valid_in=1 and busy_out=0 SHALL write address_data_in to the current word, masked by captured byte enables, then increment the word index.
REQ-020 WRITE: SHALL return to IDLE on the cycle after end_transaction_in=1; a beat and end_transaction_in in the same cycle SHALL both take effect.
REQ-021 A write beat beyond burst_size_in+1 accepted beats SHALL be discarded and SHALL cause ERROR.
REQ-022 begin_transaction_in outside IDLE SHALL be ignored.
REQ-023 Word counter SHALL be 9 bits and beat counter 9 bits; no wrap occurs because REQ-013 rejects overrun.

Reset
REQ-024 reset low SHALL immediately force state IDLE and all outputs zero, including mid-burst.
REQ-025 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro BURST_MEMORY_SLAVE_BUSY_EN defined: busy_out SHALL be high for the one cycle following every accepted write beat, limiting writes to one word per two cycles; the initiator holds data while busy_out=1.
REQ-027 Macro undefined: busy_out SHALL be constant zero and writes SHALL accept one beat per cycle.

Verification
REQ-028 Write 4 words 0x11111111..0x44444444 at BASE_ADDRESS, burst_size_in=3, then read back -> data_valid_out cycles N+2..N+5 with same values, end_transaction_out at N+6.
REQ-029 Begin at BASE_ADDRESS+0x7FC with burst_size_in=1 -> error_out one cycle, RAM unchanged, no data_valid_out.
REQ-030 Begin at 32'h20000000 -> all outputs stay zero, state stays IDLE.
REQ-031 Write 0xAABBCCDD with byte_enables_in=4'b0011 over 0x00000000 -> readback 0x0000CCDD.
REQ-032 Macro defined, 3-beat write with data_valid_in held high -> busy_out toggles 0,1,0,1,0; exactly 3 words written.
REQ-033 Reset low during 16-beat read at beat 5 -> outputs zero same cycle; after release, new read returns correct data.
